// File: rtl/router_sync_param_if.sv
// router_sync_param_if -- bundle of the FSM-side and FIFO-side signals of the
// router synchroniser. The master modport drives the request/status inputs
// (FSM, FIFOs, destinations); the slave modport is the synchroniser itself.
interface router_sync_param_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
);
  // Requests and status into the synchroniser
  logic [ADDR_W-1:0]    data_in;
  logic                 detect_add;
  logic                 write_enb_reg;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] read_enb;

  // Steering and status out of the synchroniser
  logic [NUM_PORTS-1:0] write_enb;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] vld_out;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 addr_err;

  modport master (
    output data_in, detect_add, write_enb_reg, full, empty, read_enb,
    input  write_enb, fifo_full, vld_out, soft_reset, addr_err
  );

  modport slave (
    input  data_in, detect_add, write_enb_reg, full, empty, read_enb,
    output write_enb, fifo_full, vld_out, soft_reset, addr_err
  );
endinterface

// File: rtl/router_sync_param.sv
// router_sync_param -- synchroniser between the router FSM and NUM_PORTS
// output FIFOs. Latches the destination address from the header, steers the
// write enable to that FIFO, returns its full flag, drives per-port valid and
// issues a one-cycle soft reset to any FIFO left unread for TIMEOUT cycles.
// Optional build macro ROUTER_SYNC_STATS_EN adds the sr_count output: one
// saturating 8-bit soft-reset pulse counter per port.
module router_sync_param #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = 30
) (
  input  logic                      clk,
  input  logic                      resetn,
  router_sync_param_if.slave        bus
`ifdef ROUTER_SYNC_STATS_EN
  ,
  output logic [NUM_PORTS*8-1:0]    sr_count
`endif
);

  // Counter only ever reaches TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0]    addr_reg;
  logic                 addr_err_reg;
  logic                 addr_out_of_range;
  logic [NUM_PORTS-1:0] addr_hit;
  logic [NUM_PORTS-1:0] write_enb_next;
  logic                 fifo_full_next;
  logic [NUM_PORTS-1:0] vld_out_next;
  logic [NUM_PORTS-1:0] soft_reset_reg;

  // A header addressing a non-existent port is flagged and blocks all writes.
  assign addr_out_of_range = int'(bus.data_in) >= NUM_PORTS;

  // Capture the destination address and its validity on each header strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_reg     <= '0;
      addr_err_reg <= 1'b0;
    end else if (bus.detect_add) begin
      addr_reg     <= bus.data_in;
      addr_err_reg <= addr_out_of_range;
    end
  end

  // Per-port decode of the latched address; at most one bit can match.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_decode
    assign addr_hit[gi] = (addr_reg == ADDR_W'(gi));
  end

  // Write steering and full mux are gated off while reset is held, so the FSM
  // never sees a write or full indication from a FIFO that is being reset.
  assign write_enb_next = (resetn && bus.write_enb_reg && !addr_err_reg)
                          ? addr_hit : '0;
  assign fifo_full_next = resetn && !addr_err_reg && (|(bus.full & addr_hit));

  // Valid-out is purely the inverted empty flag; no pipeline stage.
  assign vld_out_next = ~bus.empty;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [CNT_W-1:0] cnt_reg;
    logic             stall;
    logic             fire;

    // A port stalls when it holds data that the destination is not reading.
    assign stall = vld_out_next[gi] && !bus.read_enb[gi];
    // Fire on the edge that completes TIMEOUT stalled cycles; never during
    // a pulse, which is what keeps the pulse exactly one cycle wide.
    assign fire  = !soft_reset_reg[gi] && stall && (cnt_reg == CNT_LAST);

    // Stall timer: pulse clears and restarts, stall counts, anything else restarts.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_reg            <= '0;
        soft_reset_reg[gi] <= 1'b0;
      end else if (soft_reset_reg[gi]) begin
        cnt_reg            <= '0;
        soft_reset_reg[gi] <= 1'b0;
      end else if (stall) begin
        if (cnt_reg == CNT_LAST) begin
          cnt_reg            <= '0;
          soft_reset_reg[gi] <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end

`ifdef ROUTER_SYNC_STATS_EN
    logic [7:0] sr_count_reg;

    // Count issued pulses, sticking at 255 rather than wrapping.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sr_count_reg <= '0;
      end else if (fire && (sr_count_reg != 8'hFF)) begin
        sr_count_reg <= sr_count_reg + 8'd1;
      end
    end

    assign sr_count[gi*8 +: 8] = sr_count_reg;
`else
    // Without the statistics counters the fire strobe has no consumer.
    logic unused_fire;
    assign unused_fire = fire;
`endif
  end

  assign bus.write_enb  = write_enb_next;
  assign bus.fifo_full  = fifo_full_next;
  assign bus.vld_out    = vld_out_next;
  assign bus.soft_reset = soft_reset_reg;
  assign bus.addr_err   = addr_err_reg;

endmodule
